// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM solver: streams in an 8x8 worker/job cost table,
// serves registered one-cycle lookups, and captures the solver's final result.
module jam_cost_server #(
    parameter int COST_W = 7,
    parameter int RES_W  = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    output logic              table_ready,
    output logic [12:0]       table_sum,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [RES_W-1:0]  MinCost,
    input  logic [3:0]        MatchCount,
    output logic              done,
    output logic [RES_W-1:0]  res_mincost,
    output logic [3:0]        res_matchcount,
    input  logic              restart
);

    typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

    state_t              state_q, state_d;
    logic [5:0]          load_addr_q, load_addr_d;
    logic [12:0]         table_sum_q, table_sum_d;
    logic [COST_W-1:0]   cost_q, cost_d;
    logic                done_q, done_d;
    logic [RES_W-1:0]    res_mincost_q, res_mincost_d;
    logic [3:0]          res_matchcount_q, res_matchcount_d;
    logic                mem_we;

    logic [COST_W-1:0]   mem [64];

    always_comb begin
        state_d          = state_q;
        load_addr_d      = load_addr_q;
        table_sum_d      = table_sum_q;
        done_d           = done_q;
        res_mincost_d    = res_mincost_q;
        res_matchcount_d = res_matchcount_q;
        mem_we           = 1'b0;
        case (state_q)
            LOAD: begin
                if (load_valid) begin
                    mem_we      = 1'b1;
                    table_sum_d = table_sum_q + 13'(load_data);
                    load_addr_d = load_addr_q + 6'd1;
                    if (load_addr_q == 6'd63) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                if (Valid) begin
                    res_mincost_d    = MinCost;
                    res_matchcount_d = MatchCount;
                    done_d           = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                if (restart) begin
                    state_d     = LOAD;
                    load_addr_d = 6'd0;
                    table_sum_d = 13'd0;
                    done_d      = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
        // Cost reads zero in any cycle spent in LOAD, including the one right after restart
        cost_d = ((state_q != LOAD) && (state_d != LOAD)) ? mem[{W, J}] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= LOAD;
            load_addr_q      <= 6'd0;
            table_sum_q      <= 13'd0;
            cost_q           <= '0;
            done_q           <= 1'b0;
            res_mincost_q    <= '0;
            res_matchcount_q <= 4'd0;
        end else begin
            state_q          <= state_d;
            load_addr_q      <= load_addr_d;
            table_sum_q      <= table_sum_d;
            cost_q           <= cost_d;
            done_q           <= done_d;
            res_mincost_q    <= res_mincost_d;
            res_matchcount_q <= res_matchcount_d;
        end
    end

    // Table storage is never reset; stale entries survive until overwritten by a reload
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[load_addr_q] <= load_data;
        end
    end

    assign load_ready     = (state_q == LOAD);
    assign table_ready    = (state_q != LOAD);
    assign table_sum      = table_sum_q;
    assign Cost           = cost_q;
    assign done           = done_q;
    assign res_mincost    = res_mincost_q;
    assign res_matchcount = res_matchcount_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: loads tables, checks lookups against a model
// table, and exercises result capture, restart and mid-load reset.
module tb_jam_cost_server;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        load_valid = 1'b0;
    logic [6:0]  load_data = '0;
    logic        load_ready;
    logic        table_ready;
    logic [12:0] table_sum;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic [9:0]  MinCost = '0;
    logic [3:0]  MatchCount = '0;
    logic        done;
    logic [9:0]  res_mincost;
    logic [3:0]  res_matchcount;
    logic        restart = 1'b0;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [6:0]  expMem [64];
    int          expSum = 0;
    logic [6:0]  expQ [$];
    int          cyc;

    jam_cost_server #(.COST_W(7), .RES_W(10)) dut (
        .CLK(CLK), .RST(RST),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .table_ready(table_ready), .table_sum(table_sum),
        .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .done(done), .res_mincost(res_mincost), .res_matchcount(res_matchcount),
        .restart(restart)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] beatValue(input int mode, input int n);
        case (mode)
            0:       return 7'(10 * (n >> 3) + (n & 7));
            1:       return 7'd127;
            default: return 7'd5;
        endcase
    endfunction

    // Streams nBeats into the DUT starting at address 0; toggle inserts an idle cycle after each beat
    task automatic loadBeats(input int nBeats, input int mode, input bit toggle, output int cycles);
        int   accepted = 0;
        bit   ready;
        bit   phase = 1'b0;
        logic [6:0] d;
        cycles = 0;
        while (accepted < nBeats && cycles < 400) begin
            ready      = load_ready;
            d          = beatValue(mode, accepted);
            load_valid = !(toggle && phase);
            load_data  = d;
            @(negedge CLK);
            cycles++;
            if (load_valid && ready) begin
                expMem[accepted] = d;
                expSum += d;
                accepted++;
            end
            phase = !phase;
        end
        load_valid = 1'b0;
        checkOutput("loadBeats", accepted, nBeats);
    endtask

    // One lookup per cycle: drive W/J, push the model value, compare after the next edge
    task automatic applyStimulus(input logic [2:0] w, input logic [2:0] j);
        W = w;
        J = j;
        expQ.push_back(expMem[{w, j}]);
        @(negedge CLK);
        if (expQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 1, 0);
        end else begin
            checkOutput($sformatf("cost[%0d][%0d]", w, j), Cost, expQ.pop_front());
        end
    endtask

    initial begin
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rstLoadReady", load_ready, 1);
        checkOutput("rstTableReady", table_ready, 0);
        checkOutput("rstTableSum", table_sum, 0);
        checkOutput("rstCost", Cost, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstResMin", res_mincost, 0);
        checkOutput("rstResCnt", res_matchcount, 0);
        RST = 1'b0;
        expSum = 0;

        // Valid held through the whole load, including the SERVE-entry edge, must be ignored
        Valid = 1'b1;
        MinCost = 10'd999;
        MatchCount = 4'd9;
        loadBeats(64, 0, 1'b0, cyc);
        Valid = 1'b0;
        checkOutput("load1Cycles", cyc, 64);
        checkOutput("load1Ready", load_ready, 0);
        checkOutput("load1TableReady", table_ready, 1);
        checkOutput("load1Sum", table_sum, 2464);
        checkOutput("load1DoneIgnored", done, 0);

        applyStimulus(3'd3, 3'd5);
        applyStimulus(3'd7, 3'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        MinCost = 10'd215;
        MatchCount = 4'd3;
        Valid = 1'b1;
        @(negedge CLK);
        Valid = 1'b0;
        checkOutput("capDone", done, 1);
        checkOutput("capMin", res_mincost, 215);
        checkOutput("capCnt", res_matchcount, 3);
        MinCost = 10'd100;
        MatchCount = 4'd5;
        Valid = 1'b1;
        @(negedge CLK);
        Valid = 1'b0;
        checkOutput("holdMin", res_mincost, 215);
        checkOutput("holdCnt", res_matchcount, 3);
        applyStimulus(3'd4, 3'd2);

        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        expSum = 0;
        checkOutput("rsLoadReady", load_ready, 1);
        checkOutput("rsDone", done, 0);
        checkOutput("rsSum", table_sum, 0);
        checkOutput("rsTableReady", table_ready, 0);
        checkOutput("rsCost", Cost, 0);

        loadBeats(64, 0, 1'b1, cyc);
        checkOutput("load2Cycles", cyc, 127);
        checkOutput("load2TableReady", table_ready, 1);
        checkOutput("load2Sum", table_sum, expSum);

        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        checkOutput("restartInServe", load_ready, 0);
        applyStimulus(3'd0, 3'd0);
        applyStimulus(3'd7, 3'd7);
        applyStimulus(3'd5, 3'd5);

        Valid = 1'b1;
        MinCost = 10'd42;
        MatchCount = 4'd1;
        @(negedge CLK);
        Valid = 1'b0;
        checkOutput("cap2Min", res_mincost, 42);
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        expSum = 0;

        loadBeats(10, 2, 1'b0, cyc);
        checkOutput("partialSum", table_sum, 50);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        expSum = 0;
        checkOutput("midRstLoadReady", load_ready, 1);
        checkOutput("midRstTableReady", table_ready, 0);
        checkOutput("midRstSum", table_sum, 0);

        loadBeats(64, 1, 1'b0, cyc);
        checkOutput("load3Cycles", cyc, 64);
        checkOutput("load3TableReady", table_ready, 1);
        checkOutput("load3Sum", table_sum, 8128);
        applyStimulus(3'd2, 3'd6);
        applyStimulus(3'd0, 3'd0);

        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
